// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial 6502-style instruction fetch unit with valid/ready hand-off.
// Define IFETCH_VECTOR_EN to load the start PC from the FFFC/FFFD reset vector instead of RESET_PC.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_address,
  input  logic [7:0]  mem_data,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_operand,
  output logic [1:0]  instr_length,
  output logic [15:0] instr_pc
);

  localparam logic [2:0] FETCH_OP = 3'd0;
  localparam logic [2:0] FETCH_LO = 3'd1;
  localparam logic [2:0] FETCH_HI = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
`ifdef IFETCH_VECTOR_EN
  localparam logic [2:0] VEC_LO   = 3'd4;
  localparam logic [2:0] VEC_HI   = 3'd5;
`endif

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_opcode;
  logic [15:0] r_operand;
  logic [1:0]  r_length;
  logic [15:0] r_instr_pc;

  logic [1:0]  w_length;
  logic [15:0] w_pc_next;
  logic        w_fetch_state;

  // Instruction byte count from the opcode's aaabbbcc addressing-mode fields; holes in the map count as 1.
  function automatic logic [1:0] f_length(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        case (op[4:2])
          3'b011, 3'b110, 3'b111: len = 2'd3;
          3'b010:                 len = (op == 8'h89) ? 2'd1 : 2'd2;
          default:                len = 2'd2;
        endcase
      end
      2'b10: begin
        case (op[4:2])
          3'b000:         len = (op == 8'hA2) ? 2'd2 : 2'd1;
          3'b001, 3'b101: len = 2'd2;
          3'b011:         len = 2'd3;
          3'b111:         len = (op == 8'h9E) ? 2'd1 : 2'd3;
          default:        len = 2'd1;
        endcase
      end
      2'b00: begin
        case (op[4:2])
          3'b000: begin
            if (op == 8'h20)
              len = 2'd3;
            else if (op[7] && (op[6:5] != 2'b00))
              len = 2'd2;
          end
          3'b001: begin
            if ((op[7:5] != 3'd0) && (op[7:5] != 3'd2) && (op[7:5] != 3'd3))
              len = 2'd2;
          end
          3'b011: begin
            if (op[7:5] != 3'd0)
              len = 2'd3;
          end
          3'b100: len = 2'd2;
          3'b101: begin
            if ((op[7:5] == 3'd4) || (op[7:5] == 3'd5))
              len = 2'd2;
          end
          3'b111: begin
            if (op == 8'hBC)
              len = 2'd3;
          end
          default: len = 2'd1;
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign w_length      = f_length(mem_data);
  assign w_pc_next     = r_pc + 16'd1;
  assign w_fetch_state = (r_state == FETCH_OP) || (r_state == FETCH_LO) ||
                         (r_state == FETCH_HI) || (r_state == HOLD);

  always_comb begin
    mem_address = r_pc;
`ifdef IFETCH_VECTOR_EN
    if (r_state == VEC_LO)
      mem_address = 16'hFFFC;
    else if (r_state == VEC_HI)
      mem_address = 16'hFFFD;
`endif
  end

  assign instr_valid   = (r_state == HOLD);
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_length  = r_length;
  assign instr_pc      = r_instr_pc;

  // A redirect overrides whatever fetch step is in progress, including a completing hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef IFETCH_VECTOR_EN
      r_state <= VEC_LO;
      r_pc    <= 16'h0000;
`else
      r_state <= FETCH_OP;
      r_pc    <= RESET_PC;
`endif
      r_opcode   <= 8'h00;
      r_operand  <= 16'h0000;
      r_length   <= 2'd0;
      r_instr_pc <= 16'h0000;
    end else if (pc_load && w_fetch_state) begin
      r_pc    <= pc_load_value;
      r_state <= FETCH_OP;
    end else begin
      case (r_state)
        FETCH_OP: begin
          r_opcode   <= mem_data;
          r_instr_pc <= r_pc;
          r_length   <= w_length;
          r_operand  <= 16'h0000;
          r_pc       <= w_pc_next;
          r_state    <= (w_length == 2'd1) ? HOLD : FETCH_LO;
        end
        FETCH_LO: begin
          r_operand[7:0] <= mem_data;
          r_pc           <= w_pc_next;
          r_state        <= (r_length == 2'd3) ? FETCH_HI : HOLD;
        end
        FETCH_HI: begin
          r_operand[15:8] <= mem_data;
          r_pc            <= w_pc_next;
          r_state         <= HOLD;
        end
        HOLD: begin
          if (instr_ready)
            r_state <= FETCH_OP;
        end
`ifdef IFETCH_VECTOR_EN
        VEC_LO: begin
          r_pc[7:0] <= mem_data;
          r_state   <= VEC_HI;
        end
        VEC_HI: begin
          r_pc[15:8] <= mem_data;
          r_state    <= FETCH_OP;
        end
`endif
        default: r_state <= FETCH_OP;
      endcase
    end
  end

endmodule
